// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Receive-side controller between the UART RxUnit and the core's
//               peripheral bus. Synchronizes the receiver's baud-domain status
//               flags, captures each completed frame into a FIFO, exposes the
//               FIFO through a valid/ready pop port, and owns the receiver's
//               baud/parity configuration (applied only when no frame is in
//               flight).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   SYNC_STAGES  synchronizer flops on rx_active / rx_done (>= 2)
// Ports
//   clock, reset_n             system clock, async active-low reset
//   rx_active, rx_done         receiver status (baud domain)
//   rx_data[7:0], rx_error[2:0] frame data and {parity,start,stop} errors
//   cfg_we, cfg_baud, cfg_parity configuration write
//   baud_rate, parity_type     applied configuration, to the receiver
//   cfg_pending                a write is waiting to be applied
//   rd_valid/rd_ready          FIFO pop handshake
//   rd_data, rd_error          head entry (0 when empty)
//   fifo_count                 occupancy
//   overrun / ovr_clr          sticky lost-frame flag and its clear
//   drop_count                 saturating count of discarded error frames
// Build option
//   UART_RX_ERR_DROP_EN        when defined, frames with errors are dropped
//                              and counted instead of being queued
// ============================================================================
module uart_rx_ctrl #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rx_active,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  input  logic [2:0]               rx_error,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_baud,
  input  logic [1:0]               cfg_parity,
  output logic [1:0]               baud_rate,
  output logic [1:0]               parity_type,
  output logic                     cfg_pending,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic [2:0]               rd_error,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Status synchronizers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] act_sync_q, act_sync_d;
  logic [SYNC_STAGES-1:0] done_sync_q, done_sync_d;
  logic                   done_d_q;
  logic                   act_s, done_s, done_rise;

  always_comb begin
    act_sync_d  = {act_sync_q[SYNC_STAGES-2:0], rx_active};
    done_sync_d = {done_sync_q[SYNC_STAGES-2:0], rx_done};
  end

  assign act_s     = act_sync_q[SYNC_STAGES-1];
  assign done_s    = done_sync_q[SYNC_STAGES-1];
  assign done_rise = done_s & ~done_d_q;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   capt;

  always_comb begin
    state_d = state_q;
    capt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A completed frame outranks a newly starting one.
        if (done_rise)  state_d = ST_CAPT;
        else if (act_s) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (done_rise) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        capt    = 1'b1;
        state_d = act_s ? ST_RECV : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  logic [10:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;
  logic          overrun_q, overrun_d;
  logic          fifo_empty, fifo_full;
  logic          pop, push_req, push_ok, ovr_set;

`ifdef UART_RX_ERR_DROP_EN
  logic       drop_inc;
  logic [7:0] drop_count_q, drop_count_d;

  assign push_req = capt & (rx_error == 3'b000);
  assign drop_inc = capt & (rx_error != 3'b000);

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_inc && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) drop_count_q <= 8'd0;
    else          drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`else
  assign push_req   = capt;
  assign drop_count = 8'd0;
`endif

  assign fifo_empty = (fifo_count_q == '0);
  assign fifo_full  = (fifo_count_q == FULL_CNT);
  assign pop        = ~fifo_empty & rd_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign ovr_set    = push_req & fifo_full & ~pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    overrun_d    = overrun_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    if (ovr_set)      overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {rx_error, rx_data};
  end

  assign rd_valid   = ~fifo_empty;
  assign rd_data    = fifo_empty ? 8'd0 : fifo_mem[rd_ptr_q][7:0];
  assign rd_error   = fifo_empty ? 3'd0 : fifo_mem[rd_ptr_q][10:8];
  assign fifo_count = fifo_count_q;
  assign overrun    = overrun_q;

  // --------------------------------------------------------------------------
  // Configuration: held pending until the receiver is quiet
  // --------------------------------------------------------------------------
  logic [1:0] pend_baud_q, pend_baud_d;
  logic [1:0] pend_par_q, pend_par_d;
  logic [1:0] baud_rate_q, baud_rate_d;
  logic [1:0] parity_type_q, parity_type_d;
  logic       cfg_pending_q, cfg_pending_d;
  logic       cfg_apply;

  assign cfg_apply = (state_q == ST_IDLE) & ~act_s & cfg_pending_q;

  always_comb begin
    pend_baud_d   = pend_baud_q;
    pend_par_d    = pend_par_q;
    baud_rate_d   = baud_rate_q;
    parity_type_d = parity_type_q;
    cfg_pending_d = cfg_pending_q;
    if (cfg_apply) begin
      baud_rate_d   = pend_baud_q;
      parity_type_d = pend_par_q;
    end
    // A write landing on the apply edge becomes the next pending value.
    if (cfg_we) begin
      pend_baud_d   = cfg_baud;
      pend_par_d    = cfg_parity;
      cfg_pending_d = 1'b1;
    end else if (cfg_apply) begin
      cfg_pending_d = 1'b0;
    end
  end

  assign baud_rate   = baud_rate_q;
  assign parity_type = parity_type_q;
  assign cfg_pending = cfg_pending_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_sync_q    <= '0;
      done_sync_q   <= '0;
      done_d_q      <= 1'b0;
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      overrun_q     <= 1'b0;
      pend_baud_q   <= 2'd0;
      pend_par_q    <= 2'd0;
      baud_rate_q   <= 2'd0;
      parity_type_q <= 2'd0;
      cfg_pending_q <= 1'b0;
    end else begin
      act_sync_q    <= act_sync_d;
      done_sync_q   <= done_sync_d;
      done_d_q      <= done_s;
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      overrun_q     <= overrun_d;
      pend_baud_q   <= pend_baud_d;
      pend_par_q    <= pend_par_d;
      baud_rate_q   <= baud_rate_d;
      parity_type_q <= parity_type_d;
      cfg_pending_q <= cfg_pending_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. A behavioural model
//               (queue-based FIFO, edge-history timing, pending config) is
//               compared against the DUT every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
`ifdef UART_RX_ERR_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_active = 1'b0, rx_done = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic [2:0] rx_error = 3'd0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_baud = 2'd0, cfg_parity = 2'd0;
  logic [1:0] baud_rate, parity_type;
  logic       cfg_pending, rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [2:0] rd_error;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       ovr_clr = 1'b0;
  logic [7:0] drop_count;

  always #5 clock = ~clock;

  uart_rx_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_active(rx_active), .rx_done(rx_done), .rx_data(rx_data), .rx_error(rx_error),
    .cfg_we(cfg_we), .cfg_baud(cfg_baud), .cfg_parity(cfg_parity),
    .baud_rate(baud_rate), .parity_type(parity_type), .cfg_pending(cfg_pending),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_error(rd_error),
    .fifo_count(fifo_count), .overrun(overrun), .ovr_clr(ovr_clr), .drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  logic [10:0] mq[$];           // {err, data}, head at index 0
  bit          m_ovr;
  int          m_drop;
  logic [1:0]  m_baud, m_par, p_baud, p_par;
  bit          m_pend;
  logic [4:0]  a_h, d_h;        // [j] = input level sampled j edges ago
  bit          in_flight;       // a frame has started and not yet been captured

  bit auto_rand = 1'b0;
  int rdy_pct   = 50;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    mq.delete();
    m_ovr = 0; m_drop = 0;
    m_baud = 0; m_par = 0; p_baud = 0; p_par = 0; m_pend = 0;
    a_h = 0; d_h = 0; in_flight = 0;
  endtask

  // Called at each rising edge with the inputs that edge samples.
  task automatic model_edge;
    bit push_now, capt_next, apply, pop, ovr_set;
    int sz;
    if (!reset_n) begin
      model_reset();
      return;
    end
    a_h = {a_h[3:0], rx_active};
    d_h = {d_h[3:0], rx_done};
    // rx_done first seen high at edge k is queued at edge k+SYNC+1.
    push_now  = d_h[SYNC+1] & ~d_h[SYNC+2];
    capt_next = d_h[SYNC]   & ~d_h[SYNC+1];
    apply     = m_pend & ~in_flight & ~a_h[SYNC];
    in_flight = capt_next | a_h[SYNC] | (in_flight & ~push_now);

    sz  = mq.size();
    pop = (sz > 0) && rd_ready;
    ovr_set = 0;
    if (pop) void'(mq.pop_front());
    if (push_now) begin
      if (DROP_EN && rx_error != 3'd0) begin
        if (m_drop < 255) m_drop++;
      end else if (sz < DEPTH || pop) begin
        mq.push_back({rx_error, rx_data});
      end else begin
        ovr_set = 1;
      end
    end
    if (ovr_set)      m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;

    if (apply) begin
      m_baud = p_baud;
      m_par  = p_par;
    end
    if (cfg_we) begin
      p_baud = cfg_baud; p_par = cfg_parity; m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
  endtask

  task automatic compare_all;
    logic [10:0] head;
    head = (mq.size() > 0) ? mq[0] : 11'd0;
    chk("rd_valid",    rd_valid,    mq.size() > 0);
    chk("rd_data",     rd_data,     head[7:0]);
    chk("rd_error",    rd_error,    head[10:8]);
    chk("fifo_count",  fifo_count,  mq.size());
    chk("overrun",     overrun,     m_ovr);
    chk("drop_count",  drop_count,  m_drop);
    chk("baud_rate",   baud_rate,   m_baud);
    chk("parity_type", parity_type, m_par);
    chk("cfg_pending", cfg_pending, m_pend);
  endtask

  task automatic step;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
    if (auto_rand) begin
      rd_ready   = ($urandom_range(99) < rdy_pct);
      cfg_we     = ($urandom_range(15) == 0);
      cfg_baud   = 2'($urandom);
      cfg_parity = 2'($urandom);
      ovr_clr    = ($urandom_range(31) == 0);
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic [2:0] e, input int act_len, input int gap);
    if (act_len > 0) begin
      rx_active = 1'b1;
      repeat (act_len) step();
    end
    rx_done = 1'b1; rx_active = 1'b0; rx_data = d; rx_error = e;
    repeat (4) step();
    rx_done = 1'b0; rx_data = 8'($urandom); rx_error = 3'($urandom);
    repeat (gap) step();
  endtask

  task automatic chk_reset_literals;
    chk("rst rd_valid",    rd_valid,    0);
    chk("rst rd_data",     rd_data,     0);
    chk("rst rd_error",    rd_error,    0);
    chk("rst fifo_count",  fifo_count,  0);
    chk("rst overrun",     overrun,     0);
    chk("rst drop_count",  drop_count,  0);
    chk("rst baud_rate",   baud_rate,   0);
    chk("rst parity_type", parity_type, 0);
    chk("rst cfg_pending", cfg_pending, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    chk_reset_literals();
    reset_n = 1'b1;
    repeat (2) step();

    // Single frame: visible three edges after rx_done is first sampled.
    rx_data = 8'hA5; rx_error = 3'd0; rx_done = 1'b1;
    repeat (3) step();
    chk("lat rd_valid early", rd_valid, 0);
    step();
    chk("single rd_valid", rd_valid, 1);
    chk("single rd_data", rd_data, 8'hA5);
    chk("single rd_error", rd_error, 0);
    chk("single fifo_count", fifo_count, 1);
    rx_done = 1'b0; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("pop rd_valid", rd_valid, 0);
    chk("pop rd_data", rd_data, 0);
    repeat (3) step();

    // Fill and overrun
    for (int i = 1; i <= 9; i++) frame(8'(i), 3'd0, 0, 2);
    chk("fill fifo_count", fifo_count, 8);
    chk("fill overrun", overrun, 1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("fill order", rd_data, i);
      step();
    end
    rd_ready = 1'b0;
    chk("drained rd_valid", rd_valid, 0);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Full with simultaneous pop
    for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 3'd0, 0, 2);
    chk("full count", fifo_count, 8);
    rx_data = 8'h18; rx_error = 3'd0; rx_done = 1'b1;
    repeat (3) step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0; rx_done = 1'b0;
    chk("fullpop count", fifo_count, 8);
    chk("fullpop overrun", overrun, 0);
    chk("fullpop head", rd_data, 8'h11);
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("fullpop order", rd_data, 8'h10 + 8'(i));
      step();
    end
    rd_ready = 1'b0;
    step();

    // Config deferred while a frame is in flight
    rx_active = 1'b1;
    repeat (4) step();
    cfg_we = 1'b1; cfg_baud = 2'd2; cfg_parity = 2'd1;
    step();
    cfg_we = 1'b0;
    repeat (3) step();
    chk("cfg defer baud", baud_rate, 0);
    chk("cfg defer pending", cfg_pending, 1);
    rx_active = 1'b0; rx_done = 1'b1; rx_data = 8'h5A; rx_error = 3'd0;
    repeat (4) step();
    rx_done = 1'b0;
    repeat (4) step();
    chk("cfg applied baud", baud_rate, 2);
    chk("cfg applied parity", parity_type, 1);
    chk("cfg applied pending", cfg_pending, 0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    // Idle write applies one edge later.
    cfg_we = 1'b1; cfg_baud = 2'd3; cfg_parity = 2'd2;
    step();
    cfg_we = 1'b0;
    chk("cfg idle pending", cfg_pending, 1);
    step();
    chk("cfg idle baud", baud_rate, 3);
    chk("cfg idle parity", parity_type, 2);

    // Error frame
    frame(8'h3C, 3'b100, 0, 3);
    if (DROP_EN) begin
      chk("errdrop count", fifo_count, 0);
      chk("errdrop drop_count", drop_count, 1);
    end else begin
      chk("errkeep rd_error", rd_error, 3'b100);
      chk("errkeep rd_data", rd_data, 8'h3C);
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
    end

    // Reset during CAPT with three entries queued
    for (int i = 0; i < 3; i++) frame(8'h21 + 8'(i), 3'd0, 1, 2);
    chk("prereset count", fifo_count, 3);
    rx_data = 8'h77; rx_error = 3'd0; rx_done = 1'b1;
    repeat (3) step();
    reset_n = 1'b0; rx_done = 1'b0;
    #1;
    chk_reset_literals();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (6) step();
    chk("postreset rd_valid", rd_valid, 0);

    // Randomized traffic
    auto_rand = 1'b1;
    for (int f = 0; f < 120; f++) begin
      logic [2:0] e;
      rdy_pct = ((f / 20) % 2 == 1) ? 85 : 8;
      e = ($urandom_range(3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      frame(8'($urandom), e, $urandom_range(0, 5), $urandom_range(2, 6));
    end
    auto_rand = 1'b0;
    cfg_we = 1'b0; ovr_clr = 1'b0; rd_ready = 1'b1;
    repeat (12) step();
    chk("final empty", rd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
